mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/mdu_signfix.sv | 24 ++
 rtl/mul_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32M encodings, iteration count and MDU FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Number of shift-add / restoring iterations per operation
    localparam logic [5:0] MDU_ITER = 6'd32;

    // Multiply/divide unit control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } mdu_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mdu_signfix.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_signfix
//  Description : Conditional two's-complement negation (combinational).
//                Used to take operand magnitudes and to re-apply result signs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Negate when requested, otherwise pass through
    always_comb begin
        val_o = neg_i ? (~val_i + c_ONE) : val_i;
    end

endmodule : mdu_signfix
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//                restoring divide on magnitudes, one bit per cycle, with sign
//                correction folded into the CALC -> FIN transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we
);

    mdu_state_e  state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [2:0]  f3_q,       f3_d;
    logic [4:0]  rd_cap_q,   rd_cap_d;
    logic [4:0]  rd_out_q,   rd_out_d;
    logic [63:0] acc_q,      acc_d;
    logic [31:0] opnd_q,     opnd_d;     // multiplicand or divisor magnitude
    logic        sign_q,     sign_d;     // product / quotient negate flag
    logic        rsign_q,    rsign_d;    // remainder negate flag
    logic        fast_q,     fast_d;
    logic [31:0] fast_res_q, fast_res_d;
    logic [31:0] result_q,   result_d;

    // Operand signedness and special-case detection at capture
    logic        w_a_signed, w_b_signed;
    logic        w_neg_a,    w_neg_b;
    logic [31:0] w_abs_a,    w_abs_b;
    logic        w_b_zero,   w_ovf,  w_fast;

    always_comb begin
        w_a_signed = funct3[2] ? ~funct3[0] : (funct3 != F3_MULHU);
        w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
        w_neg_a    = w_a_signed & a[31];
        w_neg_b    = w_b_signed & b[31];
        w_b_zero   = (b == 32'd0);
        w_ovf      = ~funct3[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        w_fast     = funct3[2] & (w_b_zero | w_ovf);
    end

    mdu_signfix #(.WIDTH(32)) u_abs_a (.val_i(a), .neg_i(w_neg_a), .val_o(w_abs_a));
    mdu_signfix #(.WIDTH(32)) u_abs_b (.val_i(b), .neg_i(w_neg_b), .val_o(w_abs_b));

    // One iteration of shift-add multiply and of restoring divide
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_hi;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_mul_step, w_div_step;

    always_comb begin
        w_mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        w_mul_step = {w_mul_sum, acc_q[31:1]};
        w_div_hi   = acc_q[63:31];
        w_div_ge   = (w_div_hi >= {1'b0, opnd_q});
        w_div_diff = w_div_hi[31:0] - opnd_q;
        w_div_step = w_div_ge ? {w_div_diff, acc_q[30:0], 1'b1}
                              : {acc_q[62:0], 1'b0};
    end

    // Sign fixup of the finished product and of quotient/remainder
    logic [63:0] w_prod_fix;
    logic [31:0] w_div_raw, w_div_fix;
    logic        w_div_neg;
    logic [31:0] w_final;

    always_comb begin
        w_div_raw = f3_q[1] ? acc_q[63:32] : acc_q[31:0];
        w_div_neg = f3_q[1] ? rsign_q : sign_q;
    end

    mdu_signfix #(.WIDTH(64)) u_fix_prod (.val_i(acc_q),     .neg_i(sign_q),    .val_o(w_prod_fix));
    mdu_signfix #(.WIDTH(32)) u_fix_div  (.val_i(w_div_raw), .neg_i(w_div_neg), .val_o(w_div_fix));

    // Select the architectural result for the captured op
    always_comb begin
        if (f3_q[2]) begin
            w_final = w_div_fix;
        end else if (f3_q == F3_MUL) begin
            w_final = w_prod_fix[31:0];
        end else begin
            w_final = w_prod_fix[63:32];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        rd_cap_d   = rd_cap_q;
        rd_out_d   = rd_out_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        sign_d     = sign_q;
        rsign_d    = rsign_q;
        fast_d     = fast_q;
        fast_res_d = fast_res_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CALC;
                    f3_d     = funct3;
                    rd_cap_d = rd_in;
                    sign_d   = w_neg_a ^ w_neg_b;
                    rsign_d  = w_neg_a;
                    fast_d   = w_fast;
                    // Fast path preloads the counter so CALC exits next edge
                    cnt_d    = w_fast ? MDU_ITER : 6'd0;
                    if (funct3[2]) begin
                        acc_d  = {32'd0, w_abs_a};
                        opnd_d = w_abs_b;
                    end else begin
                        acc_d  = {32'd0, w_abs_b};
                        opnd_d = w_abs_a;
                    end
                    if (w_b_zero) begin
                        fast_res_d = funct3[1] ? a : 32'hFFFF_FFFF;
                    end else begin
                        fast_res_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == MDU_ITER) begin
                    state_d  = ST_FIN;
                    result_d = fast_q ? fast_res_q : w_final;
                    rd_out_d = rd_cap_q;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    acc_d = f3_q[2] ? w_div_step : w_mul_step;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            f3_q       <= 3'd0;
            rd_cap_q   <= 5'd0;
            rd_out_q   <= 5'd0;
            acc_q      <= 64'd0;
            opnd_q     <= 32'd0;
            sign_q     <= 1'b0;
            rsign_q    <= 1'b0;
            fast_q     <= 1'b0;
            fast_res_q <= 32'd0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            rd_cap_q   <= rd_cap_d;
            rd_out_q   <= rd_out_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            sign_q     <= sign_d;
            rsign_q    <= rsign_d;
            fast_q     <= fast_d;
            fast_res_q <= fast_res_d;
            result_q   <= result_d;
        end
    end

    // Status and write-port outputs
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_FIN);
        result = result_q;
        rd_out = rd_out_q;
        we     = done & (rd_out_q != 5'd0);
    end

endmodule : mul_div_unit
`default_nettype wire
